ksa: RTL and testbench

//  ARC4 key-scheduling stage: fills the 256x8 S memory with the identity permutation, then

---
 rtl/arc4_pkg.sv | 26 ++
 rtl/ksa.sv | 139 +++++++++++++
 tb/tb_ksa.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: key-scheduling state encoding, S memory depth and
// key byte extraction used by the KSA stage.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD_I,
    LATCH_I,
    LATCH_J,
    WR_J,
    WR_I
  } ksa_state_t;

  localparam int S_DEPTH       = 256;
  localparam int KEY_MAX_BYTES = 32;
  localparam int KEY_MAX_BITS  = 8 * KEY_MAX_BYTES;

  // Keys are left-justified into KEY_MAX_BITS so byte 0 is always the top byte,
  // whatever the actual key length.
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BITS-1:0] key,
                                          input logic [7:0]              idx);
    return key[KEY_MAX_BITS - 1 - 8 * int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/ksa.sv
// ARC4 key-scheduling stage: optional identity fill of S, then the keyed
// permutation, driving a shared synchronous-read S memory port.
module ksa
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter bit DO_INIT   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

  localparam int              KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [7:0]      I_LAST    = 8'(S_DEPTH - 1);

  ksa_state_t                 state, state_d;
  logic [7:0]                 i, i_d;
  logic [7:0]                 j, j_d;
  logic [7:0]                 si, si_d;
  logic [7:0]                 sj, sj_d;
  logic [KIDX_W-1:0]          kidx, kidx_d;
  logic [8*KEY_BYTES-1:0]     key_q, key_q_d;

  logic [KEY_MAX_BITS-1:0]    key_ext;
  logic [7:0]                 kb;
  logic [7:0]                 j_new;

  always_comb begin
    key_ext = '0;
    key_ext[KEY_MAX_BITS-1 -: 8*KEY_BYTES] = key_q;
  end

  assign kb    = key_byte(key_ext, 8'(kidx));
  assign j_new = j + s_rddata + kb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      si    <= '0;
      sj    <= '0;
      kidx  <= '0;
      key_q <= '0;
    end else begin
      state <= state_d;
      i     <= i_d;
      j     <= j_d;
      si    <= si_d;
      sj    <= sj_d;
      kidx  <= kidx_d;
      key_q <= key_q_d;
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path through this block can infer a latch.
  always_comb begin
    state_d  = state;
    i_d      = i;
    j_d      = j;
    si_d     = si;
    sj_d     = sj;
    kidx_d   = kidx;
    key_q_d  = key_q;
    rdy      = 1'b0;
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;

    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_q_d = key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = DO_INIT ? INIT : RD_I;
        end
      end
      INIT: begin
        s_addr   = i;
        s_wrdata = i;
        s_wren   = 1'b1;
        i_d      = i + 8'd1;
        if (i == I_LAST) begin
          kidx_d  = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        s_addr  = i;
        state_d = LATCH_I;
      end
      LATCH_I: begin
        si_d    = s_rddata;
        j_d     = j_new;
        s_addr  = j_new;
        state_d = LATCH_J;
      end
      LATCH_J: begin
        sj_d    = s_rddata;
        s_addr  = j;
        state_d = WR_J;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_d  = WR_I;
      end
      WR_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
        if (i == I_LAST) begin
          state_d = IDLE;
        end else begin
          i_d     = i + 8'd1;
          kidx_d  = (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: two instances (with and without identity fill), each
// on its own behavioural synchronous S RAM, checked against a reference KSA.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1;
  logic [23:0] key;

  logic       rdy0, wren0, rdy1, wren1;
  logic [7:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;

  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  logic       preload1;
  int         wc0, wc1;

  logic [7:0] ref_s   [0:255];
  logic [7:0] saved_s [0:255];

  logic [7:0] addr_log  [0:2047];
  logic [7:0] wdata_log [0:2047];
  logic       wren_log  [0:2047];
  logic       rdy_log   [0:2047];

  int checks = 0;
  int errors = 0;
  int done;

  always #5 clk = ~clk;

  ksa #(.KEY_BYTES(3), .DO_INIT(1'b1)) u_ksa (
    .clk(clk), .rst_n(rst_n), .en(en0), .rdy(rdy0), .key(key),
    .s_addr(addr0), .s_rddata(rdata0), .s_wrdata(wdata0), .s_wren(wren0)
  );

  ksa #(.KEY_BYTES(3), .DO_INIT(1'b0)) u_ksa_noinit (
    .clk(clk), .rst_n(rst_n), .en(en1), .rdy(rdy1), .key(key),
    .s_addr(addr1), .s_rddata(rdata1), .s_wrdata(wdata1), .s_wren(wren1)
  );

  always @(posedge clk) begin
    if (wren0) begin
      mem0[addr0] <= wdata0;
      wc0         <= wc0 + 1;
    end
    rdata0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (preload1) begin
      for (int k = 0; k < 256; k++) mem1[k] <= 8'(k);
    end else if (wren1) begin
      mem1[addr1] <= wdata1;
      wc1         <= wc1 + 1;
    end
    rdata1 <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Textbook ARC4 key schedule with a 3-byte key.
  task automatic compute_ref(input logic [23:0] k);
    logic [7:0] kbytes [0:2];
    logic [7:0] jj, t;
    kbytes[0] = k[23:16];
    kbytes[1] = k[15:8];
    kbytes[2] = k[7:0];
    for (int n = 0; n < 256; n++) ref_s[n] = 8'(n);
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      jj        = jj + ref_s[n] + kbytes[n % 3];
      t         = ref_s[n];
      ref_s[n]  = ref_s[jj];
      ref_s[jj] = t;
    end
  endtask

  task automatic check_mem(input string tag, input bit sel, input bit vs_saved);
    int nmis = 0;
    logic [7:0] v, e;
    for (int n = 0; n < 256; n++) begin
      v = sel ? mem1[n] : mem0[n];
      e = vs_saved ? saved_s[n] : ref_s[n];
      if (v !== e) nmis++;
    end
    check(tag, nmis, 0);
  endtask

  task automatic save_mem0();
    for (int n = 0; n < 256; n++) saved_s[n] = mem0[n];
  endtask

  // Starts one instance, logs its port every cycle (cycle 1 follows the start
  // edge) and returns the first cycle with rdy=1, or -1 if it never came.
  task automatic run(input bit sel, input logic [23:0] k, input bit disturb, output int dcyc);
    @(negedge clk);
    key = k;
    if (sel) en1 = 1'b1; else en0 = 1'b1;
    @(posedge clk);
    dcyc = -1;
    for (int c = 1; c <= 2000 && dcyc < 0; c++) begin
      @(negedge clk);
      if (c == 1 || c == 601) begin
        en0 = 1'b0;
        en1 = 1'b0;
      end
      addr_log[c]  = sel ? addr1  : addr0;
      wdata_log[c] = sel ? wdata1 : wdata0;
      wren_log[c]  = sel ? wren1  : wren0;
      rdy_log[c]   = sel ? rdy1   : rdy0;
      if (rdy_log[c]) dcyc = c;
      if (disturb && c == 600) begin
        key = ~k;
        if (sel) en1 = 1'b1; else en0 = 1'b1;
      end
    end
  endtask

  initial begin
    int wc_snap;
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; key = '0; preload1 = 1'b0;
    wc0 = 0; wc1 = 0;
    #1;
    check("reset_rdy", rdy0, 1'b1);
    check("reset_wren", wren0, 1'b0);
    check("reset_addr", addr0, 8'h00);
    check("reset_wrdata", wdata0, 8'h00);

    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_no_writes", wc0 + wc1, 0);
    check("idle_rdy", rdy0, 1'b1);

    // key=0: identity fill timing, i==j on the first iteration, total latency.
    run(1'b0, 24'h000000, 1'b0, done);
    check("k0_latency", done, 1537);
    check("k0_rdy_low_c1", rdy_log[1], 1'b0);
    check("k0_init_c1_wren", wren_log[1], 1'b1);
    check("k0_init_c1_addr", addr_log[1], 8'h00);
    check("k0_init_c256_addr", addr_log[256], 8'hFF);
    check("k0_init_c256_data", wdata_log[256], 8'hFF);
    check("k0_rdi_wren", wren_log[257], 1'b0);
    check("k0_latchi_addr", addr_log[258], 8'h00);
    check("k0_wrj_addr", addr_log[260], 8'h00);
    check("k0_wrj_data", wdata_log[260], 8'h00);
    check("k0_wri_addr", addr_log[261], 8'h00);
    check("k0_wri_data", wdata_log[261], 8'h00);
    compute_ref(24'h000000);
    check_mem("k0_final_s", 1'b0, 1'b0);

    // "Key": byte order through the first four j updates.
    run(1'b0, 24'h4B6579, 1'b0, done);
    check("key_latency", done, 1537);
    check("key_it0_j", addr_log[258], 8'h4B);
    check("key_it0_wrj_addr", addr_log[260], 8'h4B);
    check("key_it0_wrj_data", wdata_log[260], 8'h00);
    check("key_it0_wri_data", wdata_log[261], 8'h4B);
    check("key_it1_j", addr_log[263], 8'hB1);
    check("key_it2_j", addr_log[268], 8'h2C);
    check("key_it3_j", addr_log[273], 8'h7A);
    compute_ref(24'h4B6579);
    check_mem("key_final_s", 1'b0, 1'b0);
    save_mem0();

    // Same key with an en pulse and key change mid-run.
    run(1'b0, 24'h4B6579, 1'b1, done);
    check("busy_latency", done, 1537);
    check_mem("busy_final_s", 1'b0, 1'b1);

    // Asynchronous reset during the identity fill.
    @(negedge clk); key = 24'h1A2B3C; en0 = 1'b1;
    @(negedge clk); en0 = 1'b0;
    repeat (99) @(negedge clk);
    check("midrun_writing", wren0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_rdy", rdy0, 1'b1);
    check("midrun_rst_wren", wren0, 1'b0);
    wc_snap = wc0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrun_no_writes", wc0 - wc_snap, 0);
    check("midrun_idle_rdy", rdy0, 1'b1);

    // Clean restart after the reset, then the no-fill instance on preloaded S.
    run(1'b0, 24'h1A2B3C, 1'b0, done);
    check("restart_latency", done, 1537);
    compute_ref(24'h1A2B3C);
    check_mem("restart_final_s", 1'b0, 1'b0);
    save_mem0();

    @(negedge clk); preload1 = 1'b1;
    @(negedge clk); preload1 = 1'b0;
    run(1'b1, 24'h1A2B3C, 1'b0, done);
    check("noinit_latency", done, 1281);
    check("noinit_first_wren", wren_log[1], 1'b0);
    check_mem("noinit_final_s", 1'b1, 1'b0);
    check_mem("noinit_vs_init", 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
